// File: rtl/mem_dump_unit_pkg.sv
// Shared CPU package: post-halt memory dump state encoding and defaults.
//   dump_state_t : dump FSM states (3 bits)
//   WORD_BYTES   : bytes per memory word
//   DUMP_DEPTH   : default number of words dumped
//   DUMP_DRAIN   : default drain wait, matches pipeline depth IF..MEM
//   word_addr    : word index -> byte address
package mem_dump_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } dump_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DUMP_DEPTH = 512;
    localparam int unsigned DUMP_DRAIN = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: after the CPU halts, waits for in-flight stores to drain,
// then reads every word of main memory in ascending order and streams each
// word out over a valid/ready port.
// Ports:
//   clk        : clock, all state updates on rising edge
//   Reset      : synchronous active-high reset
//   stop       : halt indication from the CPU (one-cycle pulse suffices)
//   mem_rd_en  : read strobe to main memory
//   mem_addr   : word-aligned byte address, 0 when not reading
//   mem_rdata  : read data, valid the cycle after mem_rd_en
//   out_valid  : dump word available
//   out_ready  : consumer accepts the word
//   out_data   : dumped word
//   out_addr   : byte address of out_data
//   busy       : dump in progress (DRAIN through PRESENT)
//   done       : all words accepted, sticky until Reset
module mem_dump_unit
    import mem_dump_unit_pkg::*;
#(
    parameter int unsigned DEPTH        = DUMP_DEPTH,
    parameter int unsigned DRAIN_CYCLES = DUMP_DRAIN
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        stop,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    dump_state_t      state;
    dump_state_t      state_next;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] drain_cnt;
    logic             handshake;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (stop) state_next = ST_DRAIN;
            ST_DRAIN:   if (drain_cnt == '0) state_next = ST_READ;
            ST_READ:    state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_PRESENT;
            ST_PRESENT: begin
                if (handshake) begin
                    state_next = (index == LAST_IDX) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (state == ST_READ);
        out_valid = (state == ST_PRESENT);
        done      = (state == ST_DONE);
        busy      = (state == ST_DRAIN) || (state == ST_READ) ||
                    (state == ST_CAPTURE) || (state == ST_PRESENT);
        mem_addr  = '0;
        if (mem_rd_en) begin
            mem_addr = word_addr(32'(index));
        end
    end

    // Index stops at LAST_IDX on the final handshake, so it never wraps;
    // it is cleared again when a new dump starts.
    always_ff @(posedge clk) begin
        if (Reset) begin
            index     <= '0;
            drain_cnt <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stop) begin
                        drain_cnt <= DRAIN_LOAD;
                        index     <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    out_data <= mem_rdata;
                    out_addr <= word_addr(32'(index));
                end
                ST_PRESENT: begin
                    if (handshake && (index != LAST_IDX)) index <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit (DEPTH=8, DRAIN_CYCLES=4).
// Memory model: array with registered read port. Reference: the k-th
// accepted word must be memory word k at byte address 4*k.
module tb_mem_dump_unit;

    localparam int D  = 8;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        stop = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:D-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_idx = 0;
    int hs_cyc [D];
    logic [31:0] rx [D];

    typedef struct {
        int          stall;
        int          exp_gap;
        logic [31:0] exp_addr;
    } bp_vec_t;
    bp_vec_t tbl [D];

    mem_dump_unit #(.DEPTH(D), .DRAIN_CYCLES(DC)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .stop      (stop),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[4:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock: snapshot what the rising edge will sample, then
    // check the outcome at the following falling edge.
    task automatic tick();
        logic pv, pr, prd, prst;
        logic [31:0] pd, pa, pma;
        pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr;
        prd = mem_rd_en; pma = mem_addr; prst = Reset;
        @(negedge clk);
        cyc++;
        if (prst) begin
            exp_idx = 0;
        end else begin
            if (prd) chk("rd_addr", pma, 32'(exp_idx * 4));
            else     chk("mem_addr_idle", pma, 32'h0);
            chk("rd_while_valid", 32'(prd & pv), 32'h0);
            if (pv && pr) begin
                if (exp_idx < D) begin
                    chk("word_addr", pa, 32'(exp_idx * 4));
                    chk("word_data", pd, mem[exp_idx]);
                    rx[exp_idx]     = pd;
                    hs_cyc[exp_idx] = cyc;
                    exp_idx++;
                end else begin
                    chk("word_overrun", 32'(exp_idx), 32'(D - 1));
                end
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'h1);
                chk("hold_data", out_data, pd);
                chk("hold_addr", out_addr, pa);
            end
        end
        if (done) chk("done_quiet", {29'b0, busy, out_valid, mem_rd_en}, 32'h0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; stop = 1'b0; out_ready = 1'b0;
        tick(); tick();
        Reset = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic run_to_done(input int limit, input bit rnd_ready);
        for (int t = 0; t < limit && !done; t++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("done_reached", 32'(done), 32'h1);
        chk("word_count", 32'(exp_idx), 32'(D));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_out_addr"}, out_addr, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    task automatic preload_a();
        for (int i = 0; i < D; i++) mem[i] = 32'hA000_0000 + 32'(i);
    endtask

    initial begin
        int k, first_rd, busy_cnt, t;

        tbl[0] = '{0, 0, 32'h00};
        tbl[1] = '{1, 4, 32'h04};
        tbl[2] = '{0, 3, 32'h08};
        tbl[3] = '{5, 8, 32'h0C};
        tbl[4] = '{2, 5, 32'h10};
        tbl[5] = '{0, 3, 32'h14};
        tbl[6] = '{3, 6, 32'h18};
        tbl[7] = '{0, 3, 32'h1C};

        preload_a();
        do_reset();
        Reset = 1'b1;
        tick();
        chk_all_zero("reset");
        Reset = 1'b0;

        // Full dump with ready held high; check drain and total latency.
        out_ready = 1'b1;
        pulse_stop();
        k = 0; first_rd = -1; busy_cnt = 0;
        while (k < 200 && !done) begin
            if (mem_rd_en && first_rd < 0) first_rd = k;
            if (busy) busy_cnt++;
            tick();
            k++;
        end
        chk("first_read_cycle", 32'(first_rd), 32'(DC));
        chk("done_latency", 32'(k), 32'(DC + 3 * D));
        chk("busy_cycles", 32'(busy_cnt), 32'(DC + 3 * D));
        chk("word_count", 32'(exp_idx), 32'(D));
        for (int i = 0; i < D; i++) chk("stream_word", rx[i], 32'hA000_0000 + 32'(i));

        // Backpressure driven from the table of per-word stalls.
        do_reset();
        out_ready = 1'b0;
        pulse_stop();
        for (int w = 0; w < D; w++) begin
            t = 0;
            while (!out_valid && t < 20) begin
                tick();
                t++;
            end
            chk("bp_valid_seen", 32'(out_valid), 32'h1);
            chk("bp_addr", out_addr, tbl[w].exp_addr);
            for (int s = 0; s < tbl[w].stall; s++) begin
                tick();
                chk("bp_no_read", 32'(mem_rd_en), 32'h0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (w > 0) chk("bp_gap", 32'(hs_cyc[w] - hs_cyc[w-1]), 32'(tbl[w].exp_gap));
        end
        tick();
        chk("bp_done", 32'(done), 32'h1);

        // A store landing one cycle after stop must be seen by the dump.
        do_reset();
        preload_a();
        out_ready = 1'b1;
        pulse_stop();
        mem[2] = 32'hDEAD_BEEF;
        run_to_done(200, 1'b0);
        chk("drain_store", rx[2], 32'hDEAD_BEEF);

        // Reset during word 5's CAPTURE, then restart from word 0.
        do_reset();
        preload_a();
        out_ready = 1'b1;
        pulse_stop();
        t = 0;
        while (!(mem_rd_en && mem_addr == 32'h14) && t < 100) begin
            tick();
            t++;
        end
        chk("reach_word5_read", 32'(mem_rd_en), 32'h1);
        tick();
        Reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        Reset = 1'b0;
        tick();
        pulse_stop();
        run_to_done(200, 1'b0);

        // Stop held after DONE with ready toggling: nothing restarts.
        stop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            out_ready = ~out_ready;
            tick();
            chk("post_done_done", 32'(done), 32'h1);
            chk("post_done_valid", 32'(out_valid), 32'h0);
        end
        stop = 1'b0;

        // Ready toggling in IDLE produces nothing.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            out_ready = ~out_ready;
            tick();
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
        end

        // Random memory contents and random ready.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < D; i++) mem[i] = $urandom;
            pulse_stop();
            run_to_done(600, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Post-halt reader for the CPU's main data memory. After the pipeline raises `stop`, the block waits for in-flight stores to drain. It then reads every word of main memory in ascending order and streams each word out over a valid/ready port to the simulation harness or host. It is the read-side counterpart to the CPU's MEM-stage writes and shares the memory's read port once the core has halted.

## Interface
Parameters:
- `DEPTH`, 512: number of 32-bit words to dump. Must be ≥1 and a power of two.
- `DRAIN_CYCLES`, 4: cycles to wait after `stop` before the first read. Covers stores still in ID/EX/MEM. Must be ≥1.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `stop`, in, 1: halt indication from the CPU.
- `mem_rd_en`, out, 1: read strobe to main memory.
- `mem_addr`, out, 32: byte address, word-aligned (`index<<2`).
- `mem_rdata`, in, 32: memory read data, valid the cycle after `mem_rd_en`.
- `out_valid`, out, 1: dump word available.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, 32: dumped word.
- `out_addr`, out, 32: byte address of `out_data`.
- `busy`, out, 1: dump in progress (DRAIN through PRESENT).
- `done`, out, 1: all `DEPTH` words accepted. Sticky until `Reset`.

## Operation
- FSM states: IDLE, DRAIN, READ, CAPTURE, PRESENT, DONE.
- IDLE: all outputs 0. When `stop`=1 is sampled, load the drain counter with `DRAIN_CYCLES-1` and go to DRAIN.
  - `stop` is edge-insensitive and need only be high for one cycle.
  - Outside IDLE, `stop` is ignored.
- DRAIN: decrement each cycle. When the counter is 0, go to READ with `index`=0.
- READ: `mem_rd_en`=1 and `mem_addr`=`index<<2` for exactly this cycle, then go to CAPTURE.
- CAPTURE: register `mem_rdata` into `out_data` and `index<<2` into `out_addr`, then go to PRESENT.
- PRESENT: `out_valid`=1.
  - `out_data` and `out_addr` are held stable until `out_valid && out_ready` is sampled.
  - On that handshake: if `index`==`DEPTH-1`, go to DONE; otherwise increment `index` and go to READ.
  - `out_valid` never deasserts without a handshake.
- DONE: `done`=1, `busy`=0, `out_valid`=0. Stays until `Reset`.
- `out_ready` is ignored when `out_valid`=0.
- `index` is `$clog2(DEPTH)` bits wide. It is never incremented past `DEPTH-1`, so it does not wrap.
- `mem_addr`: zero-extend `index` and shift left by 2. Drive 0 when `mem_rd_en`=0.

## Timing
- Reset values: state=IDLE, index=0, drain counter=0, and every output=0, including `out_data` and `out_addr`.
- `Reset` asserted in any state takes effect at the next edge and aborts the dump. A later `stop` restarts the dump from index 0.
- `stop` sampled at edge T gives DRAIN for T+1 through T+`DRAIN_CYCLES`. READ is at T+`DRAIN_CYCLES`+1.
- Per word: READ, CAPTURE, PRESENT.
  - `out_valid` rises 2 cycles after `mem_rd_en`.
  - With `out_ready` held at 1, one word is produced per 3 cycles.
  - A full dump takes 3·`DEPTH`+`DRAIN_CYCLES` cycles after `stop`.
- Handshake on the last word at edge E: `done`=1 and `busy`=0 from E, i.e. visible in the cycle after E.
- `busy`=1 in DRAIN, READ, CAPTURE and PRESENT.

## Structure
- Shared CPU package holds:
  - the `dump_state_t` enum (6 states, 3 bits);
  - `WORD_BYTES`=4;
  - default constants `DUMP_DEPTH`=512 and `DUMP_DRAIN`=4, matching the pipeline depth from IF to MEM.
- Single module, no sub-module. Counters and FSM are small enough to keep inline.
- Arbitration of the memory read port between the CPU and this block is done at the top level, gated by `busy`.

## Test plan
- `DEPTH`=8, memory preloaded with word i = 0xA0000000+i, `out_ready`=1, `stop` pulsed for one cycle → 8 words 0xA0000000..0xA0000007 at `out_addr` 0x0..0x1C. `done` rises exactly 4+24 cycles after the `stop` edge.
- Backpressure: hold `out_ready`=0 for 5 cycles in word 3's PRESENT → `out_valid` stays 1, and `out_data`/`out_addr` (0x0C) stay stable. No `mem_rd_en` is issued until the handshake.
- Drain: the CPU stores 0xDEADBEEF to word 2 one cycle after `stop` → the dump reads 0xDEADBEEF for word 2.
- Reset mid-dump: assert `Reset` during word 5's CAPTURE → all outputs 0 next cycle. A new `stop` restarts at `out_addr`=0.
- `stop` held high after DONE, and `out_ready` toggling while IDLE → no restart, no `out_valid`, and `done` stays 1.
